// File: rtl/dbus_sram_resp.sv
// -----------------------------------------------------------------------------
// dbus_sram_resp
//
// Slave end of the LSU data bus link, used as the on-chip data RAM target
// behind the data bus decoder. It accepts one request at a time and spends
// WAIT_STATES cycles in WAIT. On the edge into RESP it commits a byte-lane
// masked write into local SRAM, or registers the read data. It then returns
// a single-cycle ack. An LSU flush during WAIT aborts the transaction.
//
// Optional feature (macro DBUS_RESP_MISALIGN_CHK_EN):
//   When defined, the bus checks each sel/offset pair at commit. An illegal
//   pair is acknowledged with err_o=1. It does no SRAM write and forces
//   rdata_o to 0. When undefined, err_o is always 0 and sel_i is applied
//   as given.
//
// Parameters:
//   ADDR_WIDTH   word-address bits; SRAM holds 2^ADDR_WIDTH 32-bit words
//   WAIT_STATES  cycles spent in WAIT per transaction (0..15)
//
// Ports:
//   clk      clock, rising edge
//   rst_n    synchronous active-low reset
//   req_i    request valid, held by the initiator until ack_o
//   we_i     1 = write, 0 = read
//   addr_i   byte address; [ADDR_WIDTH+1:2] word index, [1:0] lane offset
//   wdata_i  lane-aligned write data
//   sel_i    byte-lane enables
//   flush_i  LSU flush; aborts a pending transaction
//   rdata_o  read data, valid with ack_o on reads
//   ack_o    one-cycle completion pulse
//   err_o    access error, qualified by ack_o
// -----------------------------------------------------------------------------
module dbus_sram_resp #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    input  logic        flush_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;

    logic [31:0]             mem [2**ADDR_WIDTH];

    // Request captured at acceptance
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [3:0]              lat_sel;
    logic [31:0]             lat_wdata;

    // Commit-edge view of the transaction
    logic                    accept;
    logic                    commit;
    logic                    c_we;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [3:0]              c_sel;
    logic [31:0]             c_wdata;
    logic                    c_err;

`ifdef DBUS_RESP_MISALIGN_CHK_EN
    logic [1:0]              lat_off;
    logic [1:0]              c_off;

    // Legal lane patterns: full word, aligned halves, single byte at its lane.
    function automatic logic legal_pair(input logic [3:0] sel, input logic [1:0] off);
        logic ok;
        case ({sel, off})
            {4'b1111, 2'd0},
            {4'b0011, 2'd0},
            {4'b1100, 2'd2},
            {4'b0001, 2'd0},
            {4'b0010, 2'd1},
            {4'b0100, 2'd2},
            {4'b1000, 2'd3}: ok = 1'b1;
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic unused_bits;
    assign unused_bits = ^addr_i[31:ADDR_WIDTH+2];
`else
    logic unused_bits;
    assign unused_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
`endif

    always_comb begin
        // IDLE never accepts while ack_o is high, so a request is never
        // taken in its own ack cycle.
        accept  = (state == ST_IDLE) && req_i && !flush_i && !ack_o;
        commit  = 1'b0;
        c_we    = lat_we;
        c_idx   = lat_idx;
        c_sel   = lat_sel;
        c_wdata = lat_wdata;
`ifdef DBUS_RESP_MISALIGN_CHK_EN
        c_off   = lat_off;
`endif
        if (accept && (WS == 4'd0)) begin
            // With no wait states the commit happens on the acceptance edge,
            // so take the transaction straight from the bus.
            commit  = 1'b1;
            c_we    = we_i;
            c_idx   = addr_i[ADDR_WIDTH+1:2];
            c_sel   = sel_i;
            c_wdata = wdata_i;
`ifdef DBUS_RESP_MISALIGN_CHK_EN
            c_off   = addr_i[1:0];
`endif
        end else if ((state == ST_WAIT) && (cnt == 4'd1) && !flush_i) begin
            commit = 1'b1;
        end
`ifdef DBUS_RESP_MISALIGN_CHK_EN
        c_err = !legal_pair(c_sel, c_off);
`else
        c_err = 1'b0;
`endif
    end

    // Request capture (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= we_i;
            lat_idx   <= addr_i[ADDR_WIDTH+1:2];
            lat_sel   <= sel_i;
            lat_wdata <= wdata_i;
`ifdef DBUS_RESP_MISALIGN_CHK_EN
            lat_off   <= addr_i[1:0];
`endif
        end
    end

    // SRAM write port; reset discards a write due on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n && commit && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (c_sel[b]) begin
                    mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 32'h0;
        end else begin
            ack_o <= commit;
            err_o <= commit && c_err;
            if (commit && c_err) begin
                rdata_o <= 32'h0;
            end else if (commit && !c_we) begin
                rdata_o <= mem[c_idx];
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt   <= WS;
                        state <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        cnt   <= 4'd0;
                        state <= ST_IDLE;
                    end else if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= ST_RESP;
                    end else begin
                        cnt   <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Transaction already complete; flush has no effect here.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_dbus_sram_resp
//
// Directed bench for dbus_sram_resp. u_dut runs with WAIT_STATES=1 and
// u_dut0 with WAIT_STATES=0 for the throughput case. A vector table drives
// the single transactions. Hand-written sequences cover flush, reset during
// WAIT, the misalignment case, and back-to-back requests with req held.
// -----------------------------------------------------------------------------
module tb_dbus_sram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, flush;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack, err;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  sel0;
    logic [31:0] rdata0;
    logic        ack0, err0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dbus_sram_resp #(.ADDR_WIDTH(12), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .sel_i(sel), .flush_i(flush),
        .rdata_o(rdata), .ack_o(ack), .err_o(err)
    );

    dbus_sram_resp #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .sel_i(sel0), .flush_i(1'b0),
        .rdata_o(rdata0), .ack_o(ack0), .err_o(err0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on u_dut; lat counts edges from acceptance to ack.
    task automatic txn(input logic t_we, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input logic [3:0] t_sel,
                       output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; sel = t_sel;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 20);
        rd  = rdata;
        er  = err;
        req = 1'b0;
        @(posedge clk); #1;
        chk("ack pulse width", {31'b0, ack}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; flush = 1'b0;
        addr = '0; wdata = '0; sel = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; sel0 = '0;

        v[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000};
        v[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF};
        v[2]  = '{1'b1, 32'h0000_0012, 32'h00AA_0000, 4'b0100, 32'hDEAD_BEEF};
        v[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAA_BEEF};
        v[4]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 32'hDEAA_BEEF};
        v[5]  = '{1'b1, 32'h0000_0022, 32'h9ABC_0000, 4'b1100, 32'hDEAA_BEEF};
        v[6]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 32'h9ABC_5678};
        v[7]  = '{1'b1, 32'h0000_4024, 32'hCAFE_F00D, 4'b1111, 32'h9ABC_5678};
        v[8]  = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D};
        v[9]  = '{1'b1, 32'h0000_0011, 32'h0000_5500, 4'b0010, 32'hCAFE_F00D};
        v[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAA_55EF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack",    {31'b0, ack},  32'h0);
        chk("reset err",    {31'b0, err},  32'h0);
        chk("reset rdata",  rdata,         32'h0);
        chk("reset ack0",   {31'b0, ack0}, 32'h0);
        chk("reset err0",   {31'b0, err0}, 32'h0);
        chk("reset rdata0", rdata0,        32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            txn(v[i].we, v[i].addr, v[i].wdata, v[i].sel, rd, er, lat);
            chk($sformatf("vec%0d rdata", i), rd, v[i].exp_rdata);
            chk($sformatf("vec%0d err", i), {31'b0, er}, 32'h0);
            chk($sformatf("vec%0d latency", i), lat, 32'd2);
        end

        // Flush during WAIT aborts a write
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1111_1111; sel = 4'hF;
        @(posedge clk); #1;
        chk("flush accept ack", {31'b0, ack}, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush wait ack", {31'b0, ack}, 32'h0);
        @(posedge clk); #1;
        chk("flush idle ack", {31'b0, ack}, 32'h0);
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("flush after ack", {31'b0, ack}, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("flush readback", rd, 32'hDEAA_55EF);
        chk("flush next latency", lat, 32'd2);

        // Reset during WAIT discards the write
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h2222_2222; sel = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst wait ack",   {31'b0, ack}, 32'h0);
        chk("rst wait rdata", rdata,        32'h0);
        @(negedge clk);
        rst_n = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        chk("rst after ack", {31'b0, ack}, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        chk("rst readback", rd, 32'hDEAA_55EF);

        // Misaligned full-word write at 0x13
        txn(1'b1, 32'h13, 32'h5555_5555, 4'hF, rd, er, lat);
`ifdef DBUS_RESP_MISALIGN_CHK_EN
        chk("misalign err",   {31'b0, er}, 32'h1);
        chk("misalign rdata", rd,          32'h0);
`else
        chk("misalign err",   {31'b0, er}, 32'h0);
        chk("misalign rdata", rd,          32'hDEAA_55EF);
`endif
        chk("misalign latency", lat, 32'd2);
        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
`ifdef DBUS_RESP_MISALIGN_CHK_EN
        chk("misalign readback", rd, 32'hDEAA_55EF);
`else
        chk("misalign readback", rd, 32'h5555_5555);
`endif

        // Zero wait states: write, then back-to-back reads with req held
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h0BAD_F00D; sel0 = 4'hF;
        @(posedge clk); #1;
        chk("ws0 write ack", {31'b0, ack0}, 32'h1);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("ws0 write ack end", {31'b0, ack0}, 32'h0);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("ws0 ack cyc%0d", k), {31'b0, ack0}, (k % 2 == 0) ? 32'h1 : 32'h0);
            if (k % 2 == 0) begin
                chk($sformatf("ws0 rdata cyc%0d", k), rdata0, 32'h0BAD_F00D);
            end
        end
        @(negedge clk);
        req0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dbus_sram_resp.md
# dbus_sram_resp

Data bus responder that terminates the core's LSU data bus request/acknowledge protocol, acting as the slave end of the LSU-to-data-bus link. It latches one request, inserts a programmable number of wait states, and commits a byte-lane-masked write to local SRAM or returns read data with a single-cycle acknowledge. It honours the core's LSU flush by aborting in-flight transactions. It sits behind the data bus decoder as the on-chip data RAM target.

## Interface
- ADDR_WIDTH, 12, word-address bits; SRAM depth 2^ADDR_WIDTH 32-bit words (16 KiB at default).
- WAIT_STATES, 1, cycles spent in WAIT per transaction; legal range 0..15.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_i  input  1  request valid; held by initiator until ack_o.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; bits [ADDR_WIDTH+1:2] index SRAM, upper bits ignored (aliasing), [1:0] used only for alignment check.
- wdata_i  input  32  write data, lane-aligned.
- sel_i  input  4  byte-lane enables; bit n covers wdata_i[8n+7:8n].
- flush_i  input  1  LSU flush from core; aborts pending transaction.
- rdata_o  output  32  read data, valid while ack_o=1 for reads.
- ack_o  output  1  one-cycle transaction completion pulse.
- err_o  output  1  access error, qualified by ack_o.

## Operation
- FSM states IDLE, WAIT, RESP. Reset: state IDLE, ack_o=0, err_o=0, rdata_o=0, wait counter 0; SRAM contents not reset.
- IDLE: if req_i=1 and flush_i=0, latch we, word index, offset, sel, wdata; counter loads WAIT_STATES; next state WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0). If flush_i=1, no acceptance.
- WAIT: counter decrements each cycle; at counter=1 next state RESP. flush_i=1 in any WAIT cycle: next state IDLE, no write, no ack.
- Commit edge (transition into RESP): write performs mem[idx] byte lanes where sel=1, others unchanged; read registers mem[idx] into rdata_o. Commit suppressed if flush_i=1 on that edge (transition goes to IDLE instead).
- RESP: ack_o=1 for exactly one cycle; next state IDLE unconditionally; flush_i in RESP has no effect (transaction already complete).
- Write cycles: rdata_o retains previous value. rdata_o holds last read value until next read commit.
- Read-after-write to same word returns new data (commit precedes next acceptance).
- Initiator may drop or change req_i in the ack cycle; IDLE accepts only in a cycle where ack_o=0, so a request never gets accepted in its own ack cycle.

## Timing
- Acceptance cycle = cycle T where IDLE sees req_i=1, flush_i=0.
- ack_o asserted in cycle T+WAIT_STATES+1.
- Back-to-back throughput: one transaction per WAIT_STATES+2 cycles.
- ack_o, err_o, rdata_o are registered outputs; no combinational path from inputs.
- Reset mid-transaction: next cycle state IDLE, ack_o=0, pending write discarded.

## Configuration
- DBUS_RESP_MISALIGN_CHK_EN defined: at commit, legal sel/offset pairs are 1111@0, 0011@0, 1100@2, single bit n @ offset n. Any other pair (including sel=0000) yields ack_o=1 with err_o=1, no SRAM write, rdata_o=0.
- Undefined: err_o tied 0, sel_i applied as given regardless of addr_i[1:0].

## Test plan
- WAIT_STATES=1, write addr 0x10, data 0xDEADBEEF, sel 1111 at T=0 -> ack at T=2; read 0x10 -> ack at T+2, rdata 0xDEADBEEF.
- Byte write 0x12 sel 0100 data 0x00AA0000 over 0xDEADBEEF -> subsequent read returns 0xDEAABEEF.
- WAIT_STATES=0, back-to-back reads held req -> ack every 2 cycles, ack pulses 1 cycle wide.
- Write issued, flush_i=1 during WAIT -> no ack, readback shows old data; next request served normally.
- rst_n=0 in WAIT -> ack_o=0, state IDLE next cycle, write discarded; rdata_o=0.
- With DBUS_RESP_MISALIGN_CHK_EN, write sel 1111 at 0x13 -> ack=1, err=1, memory unchanged; without macro err=0 and write lands.
